// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared MIPS pipeline bundle widths, bit indices, opcodes and stage state
//
// Contents:
//   EX_W, MEM_W, WB_W           control bundle widths
//   *_BIT                       bit positions inside the MEM and WB bundles
//   OP_*                        primary opcode constants
//   stage_state_e               ID/EX stage state (RUN, STALL)
//   op_uses_rt()                 1 when the opcode reads rt as a source
package mips_pipe_pkg;

  localparam int EX_W  = 5;
  localparam int MEM_W = 3;
  localparam int WB_W  = 2;

  // MEM bundle is {Branch, MemRead, MemWrite}
  localparam int BRANCH_BIT    = 2;
  localparam int MEM_READ_BIT  = 1;
  localparam int MEM_WRITE_BIT = 0;

  // WB bundle is {RegWrite, MemtoReg}
  localparam int REG_WRITE_BIT  = 1;
  localparam int MEM_TO_REG_BIT = 0;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } stage_state_e;

  // I-type ALU ops and loads write rt, so rt is only a source for
  // R-type, stores and the two compare-and-branch ops.
  function automatic logic op_uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard check for the ID/EX stage
//
// Ports:
//   ex_valid     in   EX slot holds a real instruction
//   ex_mem_read  in   MemRead bit of the instruction in EX
//   ex_rt        in   destination register of the load in EX
//   id_op        in   opcode of the instruction in ID
//   id_rs, id_rt in   source register fields of the instruction in ID
//   hazard       out  ID instruction needs the load result one cycle too early
module hazard_detect
  import mips_pipe_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [5:0]        id_op,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  output logic              hazard
);

  logic uses_rt;
  logic rs_match;
  logic rt_match;

  always_comb begin
    uses_rt  = op_uses_rt(id_op);
    rs_match = (ex_rt == id_rs);
    rt_match = uses_rt && (ex_rt == id_rt);
    // $0 is hardwired, so a load targeting it never produces a real dependency
    hazard   = ex_valid && ex_mem_read && (ex_rt != '0) && (rs_match || rt_match);
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall, flush and event counters
//
// Optional feature macro: HAZARD_DETECT_EN (load-use detection, stall FSM, stall_cnt).
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   id_instr, id_pc4                  instruction and PC+4 held in IF/ID
//   id_rs_data, id_rt_data, id_imm    ID datapath operands
//   id_ex, id_mem, id_wb              decoded control bundles
//   id_shamt, id_bne                  shift amount, BNE flag
//   flush                             taken branch from MEM, kills the ID instruction
//   ex_*                              registered control, operands and register fields
//   ex_valid                          EX slot holds a real instruction
//   stall                             hold PC and IF/ID this cycle (combinational)
//   stall_cnt, flush_cnt              saturating event counters
module id_ex_stage
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       id_instr,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [EX_W-1:0]   id_ex,
  input  logic [MEM_W-1:0]  id_mem,
  input  logic [WB_W-1:0]   id_wb,
  input  logic [4:0]        id_shamt,
  input  logic              id_bne,
  input  logic              flush,
  output logic [EX_W-1:0]   ex_ex,
  output logic [MEM_W-1:0]  ex_mem,
  output logic [WB_W-1:0]   ex_wb,
  output logic [4:0]        ex_shamt,
  output logic              ex_bne,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_valid,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic [EX_W-1:0]   ex_ex_q,      ex_ex_d;
  logic [MEM_W-1:0]  ex_mem_q,     ex_mem_d;
  logic [WB_W-1:0]   ex_wb_q,      ex_wb_d;
  logic [4:0]        ex_shamt_q,   ex_shamt_d;
  logic              ex_bne_q,     ex_bne_d;
  logic [DATA_W-1:0] ex_pc4_q,     ex_pc4_d;
  logic [DATA_W-1:0] ex_rs_data_q, ex_rs_data_d;
  logic [DATA_W-1:0] ex_rt_data_q, ex_rt_data_d;
  logic [DATA_W-1:0] ex_imm_q,     ex_imm_d;
  logic [REG_AW-1:0] ex_rs_q,      ex_rs_d;
  logic [REG_AW-1:0] ex_rt_q,      ex_rt_d;
  logic [REG_AW-1:0] ex_rd_q,      ex_rd_d;
  logic              ex_valid_q,   ex_valid_d;
  logic [CNT_W-1:0]  flush_cnt_q,  flush_cnt_d;
  logic              hazard;

  // funct/shamt bits of the instruction word are decoded upstream
  logic unused_funct;
  assign unused_funct = ^id_instr[10:0];

`ifdef HAZARD_DETECT_EN
  stage_state_e     state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  hazard_detect #(
    .REG_AW(REG_AW)
  ) u_hazard_detect (
    .ex_valid   (ex_valid_q),
    .ex_mem_read(ex_mem_q[MEM_READ_BIT]),
    .ex_rt      (ex_rt_q),
    .id_op      (id_instr[31:26]),
    .id_rs      (id_instr[25:21]),
    .id_rt      (id_instr[20:16]),
    .hazard     (hazard)
  );

  // The bubble loaded on a stall clears ex_mem, so STALL can only last one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (hazard && !flush) state_d = STALL;
      STALL:   state_d = RUN;
      default: state_d = RUN;
    endcase
    if (flush) state_d = RUN;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  logic unused_opcode;
  assign unused_opcode = ^id_instr[31:26];
  assign hazard        = 1'b0;
  assign stall_cnt     = '0;
`endif

  // Flush outranks the hazard: the killed instruction must not hold IF/ID.
  assign stall = hazard && !flush;

  always_comb begin
    // bubble by default; only a clean cycle admits the ID instruction
    ex_ex_d      = '0;
    ex_mem_d     = '0;
    ex_wb_d      = '0;
    ex_shamt_d   = '0;
    ex_bne_d     = 1'b0;
    ex_pc4_d     = '0;
    ex_rs_data_d = '0;
    ex_rt_data_d = '0;
    ex_imm_d     = '0;
    ex_rs_d      = '0;
    ex_rt_d      = '0;
    ex_rd_d      = '0;
    ex_valid_d   = 1'b0;
    if (!flush && !hazard) begin
      ex_ex_d      = id_ex;
      ex_mem_d     = id_mem;
      ex_wb_d      = id_wb;
      ex_shamt_d   = id_shamt;
      ex_bne_d     = id_bne;
      ex_pc4_d     = id_pc4;
      ex_rs_data_d = id_rs_data;
      ex_rt_data_d = id_rt_data;
      ex_imm_d     = id_imm;
      ex_rs_d      = id_instr[25:21];
      ex_rt_d      = id_instr[20:16];
      ex_rd_d      = id_instr[15:11];
      ex_valid_d   = 1'b1;
    end
  end

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ex_q      <= '0;
      ex_mem_q     <= '0;
      ex_wb_q      <= '0;
      ex_shamt_q   <= '0;
      ex_bne_q     <= 1'b0;
      ex_pc4_q     <= '0;
      ex_rs_data_q <= '0;
      ex_rt_data_q <= '0;
      ex_imm_q     <= '0;
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
      ex_rd_q      <= '0;
      ex_valid_q   <= 1'b0;
      flush_cnt_q  <= '0;
    end else begin
      ex_ex_q      <= ex_ex_d;
      ex_mem_q     <= ex_mem_d;
      ex_wb_q      <= ex_wb_d;
      ex_shamt_q   <= ex_shamt_d;
      ex_bne_q     <= ex_bne_d;
      ex_pc4_q     <= ex_pc4_d;
      ex_rs_data_q <= ex_rs_data_d;
      ex_rt_data_q <= ex_rt_data_d;
      ex_imm_q     <= ex_imm_d;
      ex_rs_q      <= ex_rs_d;
      ex_rt_q      <= ex_rt_d;
      ex_rd_q      <= ex_rd_d;
      ex_valid_q   <= ex_valid_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign ex_ex      = ex_ex_q;
  assign ex_mem     = ex_mem_q;
  assign ex_wb      = ex_wb_q;
  assign ex_shamt   = ex_shamt_q;
  assign ex_bne     = ex_bne_q;
  assign ex_pc4     = ex_pc4_q;
  assign ex_rs_data = ex_rs_data_q;
  assign ex_rt_data = ex_rt_data_q;
  assign ex_imm     = ex_imm_q;
  assign ex_rs      = ex_rs_q;
  assign ex_rt      = ex_rt_q;
  assign ex_rd      = ex_rd_q;
  assign ex_valid   = ex_valid_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
module tb_id_ex_stage;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
`ifdef HAZARD_DETECT_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif

  localparam logic [31:0] I_LW   = 32'h8D28_0000;  // lw   $8,0($9)
  localparam logic [31:0] I_ADD  = 32'h010B_5020;  // add  $10,$8,$11
  localparam logic [31:0] I_ADDI = 32'h2128_0004;  // addi $8,$9,4

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   id_instr = '0;
  logic [DW-1:0] id_pc4 = '0, id_rs_data = '0, id_rt_data = '0, id_imm = '0;
  logic [4:0]    id_ex = '0;
  logic [2:0]    id_mem = '0;
  logic [1:0]    id_wb = '0;
  logic [4:0]    id_shamt = '0;
  logic          id_bne = 1'b0;
  logic          flush = 1'b0;
  logic [4:0]    ex_ex;
  logic [2:0]    ex_mem;
  logic [1:0]    ex_wb;
  logic [4:0]    ex_shamt;
  logic          ex_bne;
  logic [DW-1:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
  logic [AW-1:0] ex_rs, ex_rt, ex_rd;
  logic          ex_valid, stall;
  logic [CW-1:0] stall_cnt, flush_cnt;

  id_ex_stage #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_pc4(id_pc4),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_ex(id_ex), .id_mem(id_mem), .id_wb(id_wb), .id_shamt(id_shamt),
    .id_bne(id_bne), .flush(flush), .ex_ex(ex_ex), .ex_mem(ex_mem),
    .ex_wb(ex_wb), .ex_shamt(ex_shamt), .ex_bne(ex_bne), .ex_pc4(ex_pc4),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_valid(ex_valid),
    .stall(stall), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference EX slot: what the stage should hold after each edge.
  bit            m_valid;
  logic [4:0]    m_ex, m_shamt;
  logic [2:0]    m_mem;
  logic [1:0]    m_wb;
  logic          m_bne;
  logic [DW-1:0] m_pc4, m_rsd, m_rtd, m_imm;
  logic [4:0]    m_rs, m_rt, m_rd;
  int            m_scnt, m_fcnt;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_ex = '0; m_mem = '0; m_wb = '0; m_shamt = '0; m_bne = 1'b0;
    m_pc4 = '0; m_rsd = '0; m_rtd = '0; m_imm = '0;
    m_rs = '0; m_rt = '0; m_rd = '0;
    m_scnt = 0; m_fcnt = 0;
  endtask

  // A loaded value is needed by the ID instruction before it exists.
  function automatic bit model_hazard(input logic [31:0] instr);
    bit reads_rt;
    reads_rt = instr[31:26] inside {6'b000000, 6'b101011, 6'b000100, 6'b000101};
    if (!HZ || !m_valid || !m_mem[1] || m_rt == 5'd0) return 1'b0;
    return (m_rt == instr[25:21]) || (reads_rt && m_rt == instr[20:16]);
  endfunction

  task automatic model_update(input bit hz, input bit fl);
    if (fl || hz) begin
      m_valid = 0; m_ex = '0; m_mem = '0; m_wb = '0; m_shamt = '0; m_bne = 1'b0;
      m_pc4 = '0; m_rsd = '0; m_rtd = '0; m_imm = '0;
      m_rs = '0; m_rt = '0; m_rd = '0;
      if (fl) m_fcnt = (m_fcnt < CMAX) ? m_fcnt + 1 : CMAX;
      else    m_scnt = (m_scnt < CMAX) ? m_scnt + 1 : CMAX;
    end else begin
      m_valid = 1; m_ex = id_ex; m_mem = id_mem; m_wb = id_wb;
      m_shamt = id_shamt; m_bne = id_bne;
      m_pc4 = id_pc4; m_rsd = id_rs_data; m_rtd = id_rt_data; m_imm = id_imm;
      m_rs = id_instr[25:21]; m_rt = id_instr[20:16]; m_rd = id_instr[15:11];
    end
  endtask

  task automatic chk_slot(input string tag);
    chk(tag, {ex_valid, ex_ex, ex_mem, ex_wb, ex_shamt, ex_bne, ex_pc4, ex_rs_data,
              ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd},
             {m_valid, m_ex, m_mem, m_wb, m_shamt, m_bne, m_pc4, m_rsd,
              m_rtd, m_imm, m_rs, m_rt, m_rd});
    chk({tag, "_cnt"}, {stall_cnt, flush_cnt}, {CW'(m_scnt), CW'(m_fcnt)});
  endtask

  task automatic rand_datapath();
    id_pc4 = $urandom; id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
    id_shamt = 5'($urandom); id_bne = 1'($urandom);
  endtask

  // One clock: drive ID, check stall before the edge, check EX after it.
  task automatic cycle(input logic [31:0] instr, input logic [4:0] c_ex,
                       input logic [2:0] c_mem, input logic [1:0] c_wb,
                       input bit fl, output bit exp_stall, output bit obs_stall);
    bit hz;
    id_instr = instr; id_ex = c_ex; id_mem = c_mem; id_wb = c_wb; flush = fl;
    rand_datapath();
    #1;
    hz = model_hazard(instr);
    exp_stall = hz && !fl;
    obs_stall = stall;
    chk("stall", stall, exp_stall);
    @(posedge clk);
    model_update(hz, fl);
    #1;
    chk_slot("ex_slot");
  endtask

  // Present an instruction until it leaves IF/ID; returns stalls seen on the DUT.
  task automatic issue(input logic [31:0] instr, input logic [4:0] c_ex,
                       input logic [2:0] c_mem, input logic [1:0] c_wb, output int stalls);
    bit es, os;
    stalls = 0;
    for (int k = 0; k < 4; k++) begin
      cycle(instr, c_ex, c_mem, c_wb, 1'b0, es, os);
      if (os) stalls++;
      if (!es) break;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    id_instr = $urandom; id_ex = 5'($urandom); id_mem = 3'($urandom);
    id_wb = 2'($urandom); flush = 1'($urandom);
    rand_datapath();
    #2;
    model_reset();
    chk_slot("reset_slot");
    chk("reset_stall", stall, 1'b0);
    @(posedge clk);
    #1;
    chk_slot("reset_hold");
    rst_n = 1'b1;
    flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bit es, os;
    logic [5:0] ops [8];
    logic [5:0] op;
    logic [31:0] instr;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
            6'b000101, 6'b001000, 6'b001100, 6'b001101};

    do_reset();

    // load-use: add reads $8 right behind lw $8
    issue(I_LW, 5'b00001, 3'b010, 2'b10, n);
    chk("lw_stalls", n, 0);
    issue(I_ADD, 5'b10100, 3'b000, 2'b11, n);
    chk("lu_stalls", n, HZ ? 1 : 0);
    chk("lu_ex_ex", ex_ex, 5'b10100);
    chk("lu_ex_wb", ex_wb, 2'b11);
    chk("lu_ex_rd", ex_rd, 5'd10);
    chk("lu_stall_cnt", stall_cnt, HZ ? 1 : 0);

    // addi writes $8, so rt is not a source
    do_reset();
    issue(I_LW, 5'b00001, 3'b010, 2'b10, n);
    issue(I_ADDI, 5'b00001, 3'b000, 2'b11, n);
    chk("nohz_stalls", n, 0);
    chk("nohz_valid", ex_valid, 1'b1);

    // flush in the hazard cycle wins
    do_reset();
    issue(I_LW, 5'b00001, 3'b010, 2'b10, n);
    cycle(I_ADD, 5'b10100, 3'b000, 2'b11, 1'b1, es, os);
    chk("fl_stall", os, 1'b0);
    chk("fl_flush_cnt", flush_cnt, 4'd1);
    chk("fl_stall_cnt", stall_cnt, 4'd0);
    chk("fl_bubble", {ex_valid, ex_ex, ex_mem, ex_wb}, 11'd0);
    issue(I_ADD, 5'b10100, 3'b000, 2'b11, n);
    chk("fl_after_stalls", n, 0);

    // asynchronous reset in the middle of a stall
    do_reset();
    issue(I_LW, 5'b00001, 3'b010, 2'b10, n);
    id_instr = I_ADD; id_ex = 5'b10100; id_mem = 3'b000; id_wb = 2'b11;
    #1;
    chk("mid_pre_stall", stall, HZ);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_slot("mid_reset");
    chk("mid_reset_stall", stall, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(I_ADD, 5'b10100, 3'b000, 2'b11, n);
    chk("mid_reentry_stalls", n, 0);
    chk("mid_reentry_ex", {ex_valid, ex_ex}, {1'b1, 5'b10100});

    // counter saturation
    do_reset();
    for (int k = 0; k < 20; k++)
      cycle($urandom, 5'($urandom), 3'($urandom), 2'($urandom), 1'b1, es, os);
    chk("sat_flush_cnt", flush_cnt, 4'hF);

    // randomized traffic on a small register set so hazards are frequent
    do_reset();
    for (int k = 0; k < 400; k++) begin
      op = ops[$urandom_range(0, 7)];
      instr = {op, 3'b000, 2'($urandom), 3'b000, 2'($urandom), 16'($urandom)};
      cycle(instr, 5'($urandom), 3'($urandom), 2'($urandom),
            ($urandom_range(0, 7) == 0), es, os);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
